// File: rtl/hs32_mem_pkg.sv
// Shared definitions for the hs32 memory-side responder.
// Holds the responder FSM state encoding, the SRAM macro geometry
// (row width, bytes per macro) and the data word width.
package hs32_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int ROW_W      = 8;
  localparam int BANK_BYTES = 1024;
  // First address bit above one macro's byte range.
  localparam int BANK_LSB   = $clog2(BANK_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/hs32_sram_resp_if.sv
// Request/response bus between the hs32 core (master) and the SRAM
// responder (slave).
//   req_stb_i  : request valid, held with all fields until ack
//   req_we_i   : 1 = write, 0 = read
//   req_addr_i : byte address (bits [1:0] ignored)
//   req_sel_i  : byte enables for writes
//   req_dat_i  : write data
//   req_ack_o  : one-cycle completion pulse
//   req_err_o  : qualifies req_ack_o, 1 = address out of range
//   req_dat_o  : read data, valid while req_ack_o is 1
interface hs32_sram_resp_if
  import hs32_mem_pkg::*;
#(
  parameter int AW = 32
);

  logic              req_stb_i;
  logic              req_we_i;
  logic [AW-1:0]     req_addr_i;
  logic [3:0]        req_sel_i;
  logic [WORD_W-1:0] req_dat_i;
  logic              req_ack_o;
  logic              req_err_o;
  logic [WORD_W-1:0] req_dat_o;

  modport master (
    output req_stb_i, req_we_i, req_addr_i, req_sel_i, req_dat_i,
    input  req_ack_o, req_err_o, req_dat_o
  );

  modport slave (
    input  req_stb_i, req_we_i, req_addr_i, req_sel_i, req_dat_i,
    output req_ack_o, req_err_o, req_dat_o
  );

endinterface

// File: rtl/hs32_sram_resp.sv
// Memory-side responder for the hs32 core bus. Accepts single-word
// requests and drives port 0 of a row of 256x32 1RW SRAM macros,
// returning registered read data with a one-cycle ack pulse.
// Ports:
//   wb_clk_i     : clock (also clocks the macros)
//   wb_rst_ni    : asynchronous active-low reset
//   bus          : request bus, slave side
//   sram_csb_o   : per-macro chip select, active low
//   sram_web_o   : shared write enable, active low
//   sram_wmask_o : shared byte write mask
//   sram_addr_o  : shared row address
//   sram_din_o   : shared write data
//   sram_dout_i  : macro read data, bank b at [32b+31:32b]
module hs32_sram_resp
  import hs32_mem_pkg::*;
#(
  parameter int NBANKS = 2,
  parameter int AW     = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  hs32_sram_resp_if.slave          bus,
  output logic [NBANKS-1:0]        sram_csb_o,
  output logic                     sram_web_o,
  output logic [3:0]               sram_wmask_o,
  output logic [ROW_W-1:0]         sram_addr_o,
  output logic [WORD_W-1:0]        sram_din_o,
  input  logic [NBANKS*WORD_W-1:0] sram_dout_i
);

  localparam int BANK_W = AW - BANK_LSB;
  localparam int SEL_W  = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [BANK_W-1:0] NBANKS_B = BANK_W'(NBANKS);

  // Address decode
  logic [BANK_W-1:0] w_bank;
  logic [ROW_W-1:0]  w_row;
  logic              w_in_range;
  logic              w_unused;

  assign w_bank     = bus.req_addr_i[AW-1:BANK_LSB];
  assign w_row      = bus.req_addr_i[BANK_LSB-1:2];
  assign w_in_range = (w_bank < NBANKS_B);
  // Byte offset within the word is irrelevant for word accesses.
  assign w_unused   = ^bus.req_addr_i[1:0];

  // State and registered outputs
  state_e            r_state, w_state_nx;
  logic              r_we, w_we_nx;
  logic [SEL_W-1:0]  r_bank, w_bank_nx;
  logic              r_errf, w_errf_nx;
  logic [NBANKS-1:0] r_csb, w_csb_nx;
  logic              r_web, w_web_nx;
  logic [3:0]        r_wmask, w_wmask_nx;
  logic [ROW_W-1:0]  r_addr, w_addr_nx;
  logic [WORD_W-1:0] r_din, w_din_nx;
  logic              r_ack, w_ack_nx;
  logic              r_err, w_err_nx;
  logic [WORD_W-1:0] r_dat, w_dat_nx;

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path through the case leaves a
    // variable unassigned and infers a latch.
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (bus.req_stb_i) w_state_nx = w_in_range ? ISSUE : ACK;
      ISSUE:   w_state_nx = r_we ? ACK : WAIT;
      WAIT:    w_state_nx = ACK;
      ACK:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_we_nx    = r_we;
    w_bank_nx  = r_bank;
    w_errf_nx  = r_errf;
    w_csb_nx   = r_csb;
    w_web_nx   = r_web;
    w_wmask_nx = r_wmask;
    w_addr_nx  = r_addr;
    w_din_nx   = r_din;
    w_dat_nx   = r_dat;
    w_ack_nx   = 1'b0;
    w_err_nx   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.req_stb_i) begin
          w_errf_nx = ~w_in_range;
          if (w_in_range) begin
            w_we_nx    = bus.req_we_i;
            w_bank_nx  = w_bank[SEL_W-1:0];
            w_csb_nx   = ~(NBANKS'(1) << w_bank[SEL_W-1:0]);
            w_web_nx   = ~bus.req_we_i;
            w_wmask_nx = bus.req_we_i ? bus.req_sel_i : 4'b0000;
            w_addr_nx  = w_row;
            w_din_nx   = bus.req_dat_i;
          end
        end
      end
      ISSUE: begin
        // Macro latched at this edge; release it. Row/mask/data hold.
        w_csb_nx = '1;
        w_web_nx = 1'b1;
      end
      WAIT: begin
        w_dat_nx = sram_dout_i[int'(r_bank) * WORD_W +: WORD_W];
      end
      default: ;
    endcase

    // Ack follows stb at the edge entering ACK, so a request dropped
    // before completion (abandoned) produces no pulse.
    if (w_state_nx == ACK) begin
      w_ack_nx = bus.req_stb_i;
      w_err_nx = bus.req_stb_i & w_errf_nx;
    end
  end

  // Output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_we    <= 1'b0;
      r_bank  <= '0;
      r_errf  <= 1'b0;
      r_csb   <= '1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_we    <= w_we_nx;
      r_bank  <= w_bank_nx;
      r_errf  <= w_errf_nx;
      r_csb   <= w_csb_nx;
      r_web   <= w_web_nx;
      r_wmask <= w_wmask_nx;
      r_addr  <= w_addr_nx;
      r_din   <= w_din_nx;
      r_ack   <= w_ack_nx;
      r_err   <= w_err_nx;
      r_dat   <= w_dat_nx;
    end
  end

  assign sram_csb_o    = r_csb;
  assign sram_web_o    = r_web;
  assign sram_wmask_o  = r_wmask;
  assign sram_addr_o   = r_addr;
  assign sram_din_o    = r_din;
  assign bus.req_ack_o = r_ack;
  assign bus.req_err_o = r_err;
  assign bus.req_dat_o = r_dat;

endmodule

// File: tb/tb_hs32_sram_resp.sv
// Scoreboard bench for hs32_sram_resp with a behavioural model of two
// 256x32 1RW macros on port 0.
module tb_hs32_sram_resp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sram_csb_o;
  logic        sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_din_o;
  logic [63:0] sram_dout_i;

  hs32_sram_resp_if #(.AW(32)) bus ();

  hs32_sram_resp #(.NBANKS(2), .AW(32)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .bus          (bus),
    .sram_csb_o   (sram_csb_o),
    .sram_web_o   (sram_web_o),
    .sram_wmask_o (sram_wmask_o),
    .sram_addr_o  (sram_addr_o),
    .sram_din_o   (sram_din_o),
    .sram_dout_i  (sram_dout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: inputs latched at the rising edge, read data appears
  // after that edge.
  logic [31:0] mem [2][256];

  initial begin
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 256; r++) mem[b][r] = '0;
    sram_dout_i = '0;
  end

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!sram_csb_o[b]) begin
        if (!sram_web_o) begin
          for (int l = 0; l < 4; l++)
            if (sram_wmask_o[l]) mem[b][sram_addr_o][8*l +: 8] <= sram_din_o[8*l +: 8];
        end else begin
          sram_dout_i[32*b +: 32] <= mem[b][sram_addr_o];
        end
      end
    end
  end

  // Scoreboard
  typedef struct {
    string       name;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          ack_count = 0;
  logic [31:0] exp_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (rst_n && bus.req_ack_o === 1'b1) begin
      ack_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack: got ack with no outstanding request at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_err"}, {31'd0, bus.req_err_o}, {31'd0, mon_e.err});
        check({mon_e.name, "_dat"}, bus.req_dat_o, mon_e.dat);
      end
    end
  end

  // Issue one request; b2b = fields change in the ack cycle of the
  // previous request, hold = keep stb high after this ack.
  task automatic do_req(input string name, input bit b2b, input logic we,
                        input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdat, input logic exp_err,
                        input logic [31:0] exp_rd, input int exp_lat,
                        input logic [1:0] exp_csb, input bit hold);
    int         n;
    logic [1:0] csb_acc;
    exp_t       e;
    if (!b2b) @(negedge clk);
    bus.req_we_i   = we;
    bus.req_addr_i = addr;
    bus.req_sel_i  = sel;
    bus.req_dat_i  = wdat;
    bus.req_stb_i  = 1'b1;
    if (!exp_err && !we) exp_dat = exp_rd;
    e.name = name;
    e.err  = exp_err;
    e.dat  = exp_dat;
    sb.push_back(e);
    csb_acc = 2'b11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      csb_acc &= sram_csb_o;
    end while (bus.req_ack_o !== 1'b1 && n < 12);
    if (bus.req_ack_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack in %0d cycles, required ack", name, n);
    end else begin
      check({name, "_latency"}, n, exp_lat);
    end
    check({name, "_csb"}, {30'd0, csb_acc}, {30'd0, exp_csb});
    if (!hold) bus.req_stb_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_csb"},   {30'd0, sram_csb_o}, 32'h3);
    check({name, "_web"},   {31'd0, sram_web_o}, 32'h1);
    check({name, "_wmask"}, {28'd0, sram_wmask_o}, 32'h0);
    check({name, "_addr"},  {24'd0, sram_addr_o}, 32'h0);
    check({name, "_din"},   sram_din_o, 32'h0);
    check({name, "_ack"},   {31'd0, bus.req_ack_o}, 32'h0);
    check({name, "_err"},   {31'd0, bus.req_err_o}, 32'h0);
    check({name, "_dat"},   bus.req_dat_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int acks_before;

  initial begin
    rst_n          = 1'b0;
    bus.req_stb_i  = 1'b0;
    bus.req_we_i   = 1'b0;
    bus.req_addr_i = '0;
    bus.req_sel_i  = '0;
    bus.req_dat_i  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");

    // Write then read, bank 0
    do_req("wr0", 0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, '0, 2, 2'b10, 0);
    check("wr0_row", {24'd0, sram_addr_o}, 32'h04);
    check("wr0_wmask", {28'd0, sram_wmask_o}, 32'hF);
    check("wr0_din", sram_din_o, 32'hDEAD_BEEF);
    do_req("rd0", 0, 1'b0, 32'h0000_0010, 4'h0, '0, 1'b0, 32'hDEAD_BEEF, 3, 2'b10, 0);

    // Byte-lane write, bank 1
    do_req("pre1",  0, 1'b1, 32'h0000_0400, 4'hF,    32'h1122_3344, 1'b0, '0, 2, 2'b01, 0);
    do_req("lane1", 0, 1'b1, 32'h0000_0400, 4'b0101, 32'hAABB_CCDD, 1'b0, '0, 2, 2'b01, 0);
    do_req("rd1",   0, 1'b0, 32'h0000_0400, 4'h0, '0, 1'b0, 32'h11BB_33DD, 3, 2'b01, 0);

    // Out of range
    do_req("oor",    0, 1'b0, 32'h0000_0800, 4'h0, '0, 1'b1, '0, 1, 2'b11, 0);
    do_req("oor_hi", 0, 1'b1, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF, 1'b1, '0, 1, 2'b11, 0);

    // Abandoned read: stb dropped during WAIT, data still captured
    @(negedge clk);
    bus.req_we_i   = 1'b0;
    bus.req_addr_i = 32'h0000_0010;
    bus.req_stb_i  = 1'b1;
    acks_before    = ack_count;
    @(negedge clk);
    @(negedge clk);
    bus.req_stb_i = 1'b0;
    repeat (4) @(negedge clk);
    check("abandon_no_ack", ack_count, acks_before);
    exp_dat = 32'hDEAD_BEEF;
    do_req("wr_after_abandon", 1, 1'b1, 32'h0000_0408, 4'hF, 32'h600D_F00D, 1'b0, '0, 2, 2'b01, 0);

    // Reset during ISSUE of a write
    @(negedge clk);
    bus.req_we_i   = 1'b1;
    bus.req_addr_i = 32'h0000_0408;
    bus.req_sel_i  = 4'hF;
    bus.req_dat_i  = 32'hBAD0_BAD0;
    bus.req_stb_i  = 1'b1;
    acks_before    = ack_count;
    @(posedge clk);
    #1;
    check("rst_issue_csb_before", {30'd0, sram_csb_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    bus.req_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_dat = '0;
    repeat (2) @(negedge clk);
    check("rst_no_ack", ack_count, acks_before);
    do_req("rd_after_rst", 0, 1'b0, 32'h0000_0408, 4'h0, '0, 1'b0, 32'h600D_F00D, 3, 2'b01, 0);

    // Back-to-back, stb held through each ack
    do_req("bb_w0", 0, 1'b1, 32'h0000_0020, 4'hF,    32'h0123_4567, 1'b0, '0, 2, 2'b10, 1);
    do_req("bb_r0", 1, 1'b0, 32'h0000_0020, 4'h0, '0, 1'b0, 32'h0123_4567, 4, 2'b10, 1);
    do_req("bb_w1", 1, 1'b1, 32'h0000_0404, 4'hF,    32'hCAFE_F00D, 1'b0, '0, 3, 2'b01, 1);
    do_req("bb_r1", 1, 1'b0, 32'h0000_0404, 4'h0, '0, 1'b0, 32'hCAFE_F00D, 4, 2'b01, 1);
    do_req("bb_w2", 1, 1'b1, 32'h0000_0010, 4'b1000, 32'h5500_0000, 1'b0, '0, 3, 2'b10, 1);
    do_req("bb_r2", 1, 1'b0, 32'h0000_0010, 4'h0, '0, 1'b0, 32'h55AD_BEEF, 4, 2'b10, 1);
    do_req("bb_w3", 1, 1'b1, 32'h0000_0400, 4'b0010, 32'h0000_EE00, 1'b0, '0, 3, 2'b01, 1);
    do_req("bb_r3", 1, 1'b0, 32'h0000_0400, 4'h0, '0, 1'b0, 32'h11BB_EEDD, 4, 2'b01, 0);

    // Write with empty byte mask leaves memory unchanged
    do_req("sel0_wr", 0, 1'b1, 32'h0000_0404, 4'h0, 32'hFFFF_FFFF, 1'b0, '0, 2, 2'b01, 0);
    do_req("sel0_rd", 0, 1'b0, 32'h0000_0404, 4'h0, '0, 1'b0, 32'hCAFE_F00D, 3, 2'b01, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs32_sram_resp.md
# hs32_sram_resp

Memory-side responder for the hs32 core's data/instruction bus. It accepts single-word requests from the core, which acts as initiator, and drives the 1RW port (port 0) of a row of `sram_1rw1r_32_256_8_sky130` macros. It returns registered read data with a one-cycle `req_ack_o` pulse. It sits between `hs32_core1` and the SRAM macros in `user_project_wrapper`, replacing the core's direct `cpu_*` macro wiring with a handshaked interface.

## Interface
- `NBANKS`, default 2: number of macros; each macro holds 256 words of 32 bits (1 KiB).
- `AW`, default 32: request address width, byte address.
- `wb_clk_i  in  1`: the single clock. Macros are clocked by the same net.
- `wb_rst_ni  in  1`: reset, asynchronous assert, active low.
- `req_stb_i  in  1`: request valid. Held with all request fields until ack.
- `req_we_i  in  1`: 1 = write, 0 = read.
- `req_addr_i  in  AW`: byte address. Bits [1:0] are ignored.
- `req_sel_i  in  4`: byte enables for writes; bit i maps to byte lane i.
- `req_dat_i  in  32`: write data.
- `req_ack_o  out  1`: one-cycle completion pulse.
- `req_err_o  out  1`: qualifies `req_ack_o`; 1 means the address was out of range.
- `req_dat_o  out  32`: read data, valid while `req_ack_o` is 1.
- `sram_csb_o  out  NBANKS`: per-macro chip select, active low.
- `sram_web_o  out  1`: shared write enable, active low.
- `sram_wmask_o  out  4`: shared write mask.
- `sram_addr_o  out  8`: shared row address.
- `sram_din_o  out  32`: shared write data.
- `sram_dout_i  in  NBANKS*32`: macro read data. Bank b occupies bits [32b+31:32b].

## Operation
- Address decode:
  - row = `req_addr_i[9:2]`
  - bank = `req_addr_i[AW-1:10]`
  - The address is in range iff bank < `NBANKS`.
- FSM states are IDLE, ISSUE, WAIT and ACK.
- IDLE:
  - If `req_stb_i` is 1 and the address is in range, register the macro controls and go to ISSUE:
    - `sram_csb_o` = one-hot-low for the selected bank
    - `sram_web_o` = ~`req_we_i`
    - `sram_wmask_o` = `req_sel_i` for writes, 0 for reads
    - `sram_addr_o` = row
    - `sram_din_o` = `req_dat_i`
  - If `req_stb_i` is 1 and the address is out of range, go directly to ACK with the error flag set. No macro is touched.
- ISSUE: the selected macro samples its inputs at the closing edge. Go to WAIT for reads, or to ACK for writes. On leaving ISSUE, `sram_csb_o` returns to all ones and `sram_web_o` to 1.
- WAIT: at the closing edge, capture the selected bank's 32-bit slice of `sram_dout_i` into `req_dat_o`. Go to ACK.
- ACK:
  - `req_ack_o` = `req_stb_i`; `req_err_o` = error flag and `req_stb_i`.
  - Always return to IDLE.
  - If `req_stb_i` has dropped, the access still completes internally and no ack is emitted (abandoned request).
- Write with `req_sel_i` = 0: full macro cycle with mask 0. Memory is unchanged and the ack is normal.
- Writes leave `req_dat_o` unchanged.
- Reset, including mid-transaction: state becomes IDLE and the outputs take these values:
  - `sram_csb_o` all ones, `sram_web_o` 1
  - `sram_wmask_o`, `sram_addr_o`, `sram_din_o` 0
  - `req_ack_o` 0, `req_err_o` 0, `req_dat_o` 0
- No ack is produced for a request interrupted by reset.

## Timing
- Let edge E0 be the first rising edge that samples `req_stb_i` = 1 in IDLE.
- Read: macro pins driven after E0, macro latches at E1, data captured at E2. `req_ack_o` is high for the cycle between E2 and E3.
- Write: macro latches at E1. `req_ack_o` is high between E1 and E2.
- Out-of-range: `req_ack_o` and `req_err_o` are high between E0 and E1.
- Back-to-back requests: IDLE is re-entered after ACK. A stb still high in the ack cycle is not sampled as new; the earliest next request is sampled at the edge that ends the following IDLE cycle.
- Throughput: one read per 4 cycles, one write per 3 cycles.
- All outputs are registered; there is no combinational path from `req_*` inputs to `req_*` or `sram_*` outputs.

## Structure
- Shared package `hs32_mem_pkg` holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, ACK)
  - `ROW_W` = 8
  - `BANK_BYTES` = 1024
  - the 32-bit word width
- Single module with no sub-modules. The read-slice mux is an indexed part-select.
- In the wrapper, `sram_csb_o[b]`, `sram_web_o`, `sram_wmask_o`, `sram_addr_o` and `sram_din_o` connect to macro b's port-0 pins (`csb0`, `web0`, `wmask0`, `addr0`, `din0`). Port 1 is tied off (`csb1` = 1).

## Test plan
- Reset: hold `wb_rst_ni` = 0, then release → all outputs at reset values, `sram_csb_o` = 2'b11, no ack.
- Write then read, bank 0:
  - write addr 0x0000_0010, data 0xDEADBEEF, sel 4'hF → ack 2 cycles after the stb sample, `sram_csb_o` = 2'b10, row 0x04
  - read same address → ack 3 cycles after the stb sample, `req_dat_o` = 0xDEADBEEF
- Byte-lane write, bank 1:
  - preload 0x1122_3344 at 0x0000_0400
  - write 0xAABBCCDD with sel 4'b0101
  - read back → 0x11BB_33DD, `sram_csb_o` = 2'b01 during the access
- Out of range: read 0x0000_0800 with NBANKS = 2 → `req_ack_o` = `req_err_o` = 1 one cycle after the sample, `sram_csb_o` stays 2'b11.
- Abandoned and reset: drop stb during WAIT → no ack, FSM back to IDLE. Assert reset during ISSUE of a write → csb high immediately, no ack. A subsequent read of that address returns the pre-write value.
- Back-to-back: 8 alternating writes and reads across both banks with stb re-asserted right after each ack → every ack corresponds to exactly one request, data matches a scoreboard model, and no stb is sampled in an ACK cycle.
